// File: rtl/fifo_pkt_writer_if.sv
// Stream-in / FIFO-write bundle for fifo_pkt_writer.
// master = the packet writer, slave = upstream source plus FIFO write port.
interface fifo_pkt_writer_if #(
  parameter int unsigned DW = 8
);
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic          full;
  logic          wr;
  logic [DW-1:0] dout;
  logic          busy;
  logic          trunc_err;
  logic [15:0]   pkt_cnt;

  modport master (
    input  s_valid, s_data, s_last, full,
    output s_ready, wr, dout, busy, trunc_err, pkt_cnt
  );

  modport slave (
    output s_valid, s_data, s_last, full,
    input  s_ready, wr, dout, busy, trunc_err, pkt_cnt
  );
endinterface

// File: rtl/fifo_pkt_writer.sv
// Stages one upstream packet, then pushes [len, payload...] into the FIFO (clk1 domain).
// Optional trailing XOR checksum byte when PKT_CHECKSUM_EN is defined.
module fifo_pkt_writer #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned DW      = 8
) (
  input  logic             clk1,
  input  logic             rst,
  fifo_pkt_writer_if.master bus
);

  localparam int unsigned LW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

`ifdef PKT_CHECKSUM_EN
  typedef enum logic [1:0] {COLLECT, HDR, PAY, CHK} state_t;
`else
  typedef enum logic [1:0] {COLLECT, HDR, PAY} state_t;
`endif

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_buf [MAX_LEN];
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_idx;
  logic          r_ovf;
  logic          r_trunc;
  logic [CW-1:0] r_pkt_cnt;
`ifdef PKT_CHECKSUM_EN
  logic [DW-1:0] r_xor;
`endif

  logic          w_accept;
  logic          w_room;
  logic          w_wr;
  logic [DW-1:0] w_dout;
  logic          w_hdr_xfer;
  logic          w_pay_xfer;
  logic          w_pay_done;
  logic          w_pkt_done;

  assign w_room = (r_len < LW'(MAX_LEN));

  // State register; async reset also kills wr mid-push
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) r_state <= COLLECT;
    else     r_state <= w_next;
  end

  // Next state and combinational FIFO-side outputs
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_wr       = 1'b0;
    w_dout     = '0;
    w_hdr_xfer = 1'b0;
    w_pay_xfer = 1'b0;
    w_pay_done = 1'b0;
    w_pkt_done = 1'b0;
    case (r_state)
      COLLECT: begin
        w_accept = bus.s_valid;
        if (w_accept && bus.s_last) w_next = HDR;
      end
      HDR: begin
        w_dout     = DW'(r_len);
        w_wr       = !bus.full;
        w_hdr_xfer = w_wr;
        if (w_wr) w_next = PAY;
      end
      PAY: begin
        w_dout     = r_buf[AW'(r_idx)];
        w_wr       = !bus.full;
        w_pay_xfer = w_wr;
        if (w_wr && (r_idx == r_len - LW'(1))) begin
          w_pay_done = 1'b1;
`ifdef PKT_CHECKSUM_EN
          w_next     = CHK;
`else
          w_next     = COLLECT;
          w_pkt_done = 1'b1;
`endif
        end
      end
`ifdef PKT_CHECKSUM_EN
      CHK: begin
        w_dout = r_xor;
        w_wr   = !bus.full;
        if (w_wr) begin
          w_next     = COLLECT;
          w_pkt_done = 1'b1;
        end
      end
`endif
      default: w_next = COLLECT;
    endcase
  end

  // Length, read index, overflow tracking and packet counter
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_len     <= '0;
      r_idx     <= '0;
      r_ovf     <= 1'b0;
      r_trunc   <= 1'b0;
      r_pkt_cnt <= '0;
`ifdef PKT_CHECKSUM_EN
      r_xor     <= '0;
`endif
    end else begin
      r_trunc <= 1'b0;
      if (w_accept) begin
        if (w_room) begin
          r_len <= r_len + LW'(1);
`ifdef PKT_CHECKSUM_EN
          r_xor <= r_xor ^ bus.s_data;
`endif
        end else begin
          r_ovf <= 1'b1;
        end
        if (bus.s_last) r_trunc <= r_ovf | !w_room;
      end
      if (w_hdr_xfer) r_idx <= '0;
      if (w_pay_xfer) r_idx <= r_idx + LW'(1);
      if (w_pay_done) begin
        r_len <= '0;
        r_ovf <= 1'b0;
      end
      if (w_pkt_done) begin
        r_pkt_cnt <= r_pkt_cnt + CW'(1);
`ifdef PKT_CHECKSUM_EN
        r_xor     <= '0;
`endif
      end
    end
  end

  // Staging buffer; contents after reset are don't-care
  always_ff @(posedge clk1) begin
    if (w_accept && w_room) r_buf[AW'(r_len)] <= bus.s_data;
  end

  assign bus.wr        = w_wr;
  assign bus.dout      = w_dout;
  assign bus.busy      = (r_state != COLLECT);
  assign bus.s_ready   = (r_state == COLLECT);
  assign bus.trunc_err = r_trunc;
  assign bus.pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Directed bench for fifo_pkt_writer: framing, stalls, truncation, reset and back-to-back packets.
module tb_fifo_pkt_writer;

  localparam int unsigned DW      = 8;
  localparam int unsigned MAX_LEN = 32;

  typedef logic [7:0] byte_q_t[$];

  logic clk1 = 1'b0;
  logic rst  = 1'b1;

  fifo_pkt_writer_if #(.DW(DW)) bus ();

  fifo_pkt_writer #(.MAX_LEN(MAX_LEN), .DW(DW)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] wq[$];
  int         wcyc[$];
  int         rd_ptr    = 0;
  int         trunc_cnt = 0;
  int         busy_cnt  = 0;
  int         wf_viol   = 0;
  int         rdy_viol  = 0;

  always @(posedge clk1) cyc <= cyc + 1;

  // FIFO-side monitor, sampled mid-cycle
  always @(negedge clk1) begin
    if (!rst) begin
      if (bus.wr) begin
        wq.push_back(bus.dout);
        wcyc.push_back(cyc);
      end
      if (bus.wr && bus.full)    wf_viol++;
      if (bus.wr && bus.s_ready) rdy_viol++;
      if (bus.trunc_err)         trunc_cnt++;
      if (bus.busy)              busy_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    bit done;
    done = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk1);
      if (bus.s_ready) begin
        @(posedge clk1);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic send_pkt(input byte_q_t b, input bit hold);
    foreach (b[i]) send_byte(b[i], (i == b.size() - 1));
    if (!hold) begin
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk1);
      if (!bus.busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 32'(0), 32'(1));
  endtask

  task automatic expect_stream(input string tag, input byte_q_t e);
    chk({tag, "_n"}, 32'(wq.size() - rd_ptr), 32'(e.size()));
    foreach (e[i]) begin
      if (rd_ptr + i < wq.size())
        chk($sformatf("%s_b%0d", tag, i), 32'(wq[rd_ptr + i]), 32'(e[i]));
      else
        chk($sformatf("%s_b%0d_missing", tag, i), 32'hDEAD, 32'(e[i]));
    end
    rd_ptr = wq.size();
  endtask

  task automatic do_reset();
    @(posedge clk1);
    #1;
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.full    = 1'b0;
    @(posedge clk1);
    #1;
    rst    = 1'b0;
    rd_ptr = wq.size();
  endtask

  byte_q_t p;
  byte_q_t e;
  int      t0;
  int      b0;
  int      nw;
  bit      seen;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.full    = 1'b0;

    // reset values
    #7;
    chk("rst_s_ready", 32'(bus.s_ready), 32'(1));
    chk("rst_wr", 32'(bus.wr), 32'(0));
    chk("rst_dout", 32'(bus.dout), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_trunc", 32'(bus.trunc_err), 32'(0));
    chk("rst_pkt_cnt", 32'(bus.pkt_cnt), 32'(0));
    @(posedge clk1);
    #1;
    rst = 1'b0;

    // basic 3-byte packet
    t0 = trunc_cnt;
    p  = '{8'hA1, 8'hB2, 8'hC3};
    send_pkt(p, 1'b0);
    b0 = cyc;
    wait_idle();
    e = '{8'h03, 8'hA1, 8'hB2, 8'hC3};
`ifdef PKT_CHECKSUM_EN
    e.push_back(8'hD0);
`endif
    chk("t1_latency", 32'(wcyc[rd_ptr] - b0), 32'(0));
    chk("t1_consec", 32'(wcyc[rd_ptr + e.size() - 1] - wcyc[rd_ptr]), 32'(e.size() - 1));
    expect_stream("t1", e);
    chk("t1_pkt_cnt", 32'(bus.pkt_cnt), 32'(1));
    chk("t1_trunc", 32'(trunc_cnt - t0), 32'(0));

    // full stall after the 0xA1 write
    do_reset();
    seen = 1'b0;
    fork
      send_pkt(p, 1'b0);
      begin
        for (int i = 0; i < 100 && !seen; i++) begin
          @(negedge clk1);
          if (bus.wr && bus.dout == 8'hA1) seen = 1'b1;
        end
        chk("t2_seen_a1", 32'(seen), 32'(1));
        @(posedge clk1);
        #1;
        bus.full = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk1);
          chk("t2_stall_wr", 32'(bus.wr), 32'(0));
          chk("t2_stall_dout", 32'(bus.dout), 32'hB2);
        end
        @(posedge clk1);
        #1;
        bus.full = 1'b0;
      end
    join
    wait_idle();
    expect_stream("t2", e);
    chk("t2_pkt_cnt", 32'(bus.pkt_cnt), 32'(1));

    // truncation: 40 bytes into a 32-byte buffer
    do_reset();
    t0 = trunc_cnt;
    p  = {};
    for (int i = 0; i < 40; i++) p.push_back(8'(i));
    send_pkt(p, 1'b0);
    wait_idle();
    e = '{8'h20};
    for (int i = 0; i < 32; i++) e.push_back(8'(i));
`ifdef PKT_CHECKSUM_EN
    e.push_back(8'h00);
`endif
    expect_stream("t3", e);
    chk("t3_trunc_pulses", 32'(trunc_cnt - t0), 32'(1));
    chk("t3_pkt_cnt", 32'(bus.pkt_cnt), 32'(1));

    // single-byte packet
    do_reset();
    b0 = busy_cnt;
    p  = '{8'h55};
    send_pkt(p, 1'b0);
    wait_idle();
    e = '{8'h01, 8'h55};
`ifdef PKT_CHECKSUM_EN
    e.push_back(8'h55);
    chk("t4_busy_cycles", 32'(busy_cnt - b0), 32'(3));
`else
    chk("t4_busy_cycles", 32'(busy_cnt - b0), 32'(2));
`endif
    expect_stream("t4", e);
    chk("t4_s_ready", 32'(bus.s_ready), 32'(1));

    // reset during PAY after two payload bytes
    do_reset();
    p  = '{8'hA1, 8'hB2, 8'hC3};
    send_pkt(p, 1'b0);
    nw = 0;
    for (int i = 0; i < 50 && nw < 3; i++) begin
      @(negedge clk1);
      if (bus.wr) nw++;
    end
    chk("t5_writes_before_rst", 32'(nw), 32'(3));
    @(posedge clk1);
    #1;
    chk("t5_pre_rst_wr", 32'(bus.wr), 32'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_wr", 32'(bus.wr), 32'(0));
    chk("t5_rst_pkt_cnt", 32'(bus.pkt_cnt), 32'(0));
    @(posedge clk1);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_s_ready", 32'(bus.s_ready), 32'(1));
    rd_ptr = wq.size();
    p = '{8'h11};
    send_pkt(p, 1'b0);
    wait_idle();
    e = '{8'h01, 8'h11};
`ifdef PKT_CHECKSUM_EN
    e.push_back(8'h11);
`endif
    expect_stream("t5", e);
    chk("t5_pkt_cnt", 32'(bus.pkt_cnt), 32'(1));

    // back-to-back packets with s_valid held high
    do_reset();
    p = '{8'h01, 8'h02};
    send_pkt(p, 1'b1);
    p = '{8'h03};
    send_pkt(p, 1'b0);
    wait_idle();
    e = '{8'h02, 8'h01, 8'h02};
`ifdef PKT_CHECKSUM_EN
    e.push_back(8'h03);
`endif
    e.push_back(8'h01);
    e.push_back(8'h03);
`ifdef PKT_CHECKSUM_EN
    e.push_back(8'h03);
`endif
    expect_stream("t6", e);
    chk("t6_pkt_cnt", 32'(bus.pkt_cnt), 32'(2));

    chk("wr_while_full", 32'(wf_viol), 32'(0));
    chk("ready_while_wr", 32'(rdy_viol), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
